nv_nvdla_sdp_erdma_ig: RTL
==========================

# nv_nvdla_sdp_erdma_ig

ERDMA ingress request generator. It walks a 2-D surface in 32-byte atoms and splits each row into DMA read requests of at most 8 atoms that never cross a 256-byte boundary. For every request it issues, it pushes one context word into the ERDMA context queue. The egress stage later uses that word to reassemble the returned data. The block sits between the SDP register block (layer config and start) and the read-DMA request port plus the context queue's `ig2cq` write interface.

## Interface

**Parameters**
- `AW`, default 64: DMA address width.
- `CQ_PD_W`, default 16: context-queue payload width.

**Ports**
- `nvdla_core_clk`, in, 1: clock.
- `nvdla_core_rst`, in, 1: reset. Asynchronous, active-high.
- `op_load`, in, 1: single-cycle layer start pulse.
- `reg2dp_base_addr`, in, AW: surface base address. Bits [4:0] are ignored (32B-aligned).
- `reg2dp_width`, in, 13: atoms per row minus 1.
- `reg2dp_height`, in, 13: rows minus 1.
- `reg2dp_line_stride`, in, AW: byte distance between row starts. Bits [4:0] are ignored.
- `dma_rd_req_pvld`, out, 1: request valid.
- `dma_rd_req_prdy`, in, 1: request ready.
- `dma_rd_req_pd`, out, AW+15: request payload, `{size[14:0], addr[AW-1:0]}`. `size` is atoms minus 1.
- `ig2cq_pvld`, out, 1: context valid.
- `ig2cq_prdy`, in, 1: context-queue ready.
- `ig2cq_pd`, out, CQ_PD_W: context payload. Bits [2:0] = atoms−1, bit [3] = end-of-row, bit [4] = end-of-surface, bits [15:5] = 0.
- `op_busy`, out, 1: high from the cycle after an accepted `op_load` until the layer's last request fires.
- `op_done`, out, 1: one-cycle pulse after the last request fires.

## Operation

**State machine: IDLE and REQ.**
- In IDLE, `op_load` latches all `reg2dp_*` inputs, initialises the counters and moves to REQ.
- In REQ, `op_load` is ignored; there is no queuing or restart.
- REQ returns to IDLE on the fire of the request that is both last in its row and in the last row. That same transition registers `op_done`=1 for one cycle.

**Counters**
- `row_addr`: set to base on load. Advances by `line_stride` modulo 2^AW at end of row.
- `cur_addr`: set to `row_addr` at the start of each row. Advances by atoms×32 per fire.
- `atoms_left`: 14 bits. Set to `width`+1 at the start of each row.
- `rows_left`: 13 bits. Set to `height` on load; decremented at each end of row.

**Request size**
- atoms = min(`atoms_left`, 8 − `cur_addr[7:5]`), which is always in the range 1..8.
- End-of-row is `atoms_left` == atoms.
- End-of-surface is end-of-row && `rows_left` == 0.

**Handshake**
- `dma_rd_req_pvld` = REQ && `ig2cq_prdy`.
- `ig2cq_pvld` = REQ && `dma_rd_req_prdy`.
- fire = REQ && `dma_rd_req_prdy` && `ig2cq_prdy`.
- Each request therefore transfers on both interfaces in the same cycle or on neither. This guarantees exactly one context word per DMA request.
- Both payloads are combinational functions of the registered state. They are stable while stalled.
- Counters update only on fire.

**Reset and boundary behaviour**
- Reset values: state IDLE; all counters 0; `dma_rd_req_pvld`=0, `ig2cq_pvld`=0, `op_busy`=0, `op_done`=0. The payload outputs are 0 in IDLE.
- Reset asserted mid-layer abandons the layer immediately. Any request already fired stays issued. The next `op_load` restarts from `base_addr`.
- Width of 8192 atoms (`reg2dp_width`=8191) fits in `atoms_left`.
- Address overflow wraps silently.

## Timing

- `op_load` in cycle T: `op_busy` and the first valid appear in cycle T+1.
- Throughput is one request per cycle when both ready inputs are held high.
- The last fire in cycle L gives `op_done`=1 and `op_busy`=0 in L+1.
- A new `op_load` is accepted in L+1 or later.
- The valid outputs have a combinational path from the opposite interface's ready. The block has no other ready→valid paths.

## Test plan

1. **Single atom.** Base 0x1000, width=0, height=0, both ready high. Expect one fire at T+1 with addr 0x1000, size 0 and `ig2cq_pd`=0x0018. `op_done` pulses at T+2.
2. **256B split.** Base 0x10E0, width=9, height=0. Expect three requests:
   - 0x10E0, size 0, cq 0x0000
   - 0x1100, size 7, cq 0x0007
   - 0x1200, size 0, cq 0x0018
3. **Multi-row stride.** Base 0x2000, width=7, height=2, stride 0x400. Expect:
   - 0x2000 / cq 0x000F
   - 0x2400 / cq 0x000F
   - 0x2800 / cq 0x001F

   All three have size 7, on consecutive cycles.
4. **Backpressure.**
   - Hold `ig2cq_prdy`=0 for 5 cycles mid-layer: `dma_rd_req_pvld`=0, no fires, payloads unchanged.
   - Then drop `dma_rd_req_prdy`: `ig2cq_pvld`=0.
   - The request sequence must equal the one from scenario 3.
5. **Reset mid-layer.** Run scenario 3, assert reset after 2 fires. All outputs go to 0 asynchronously. After release, `op_load` reissues from 0x2000.
6. **Start while busy.** Pulse `op_load` with a different base during REQ. It is ignored; the original sequence completes and `op_done` pulses exactly once.

Source files
------------

// File: rtl/nv_nvdla_sdp_erdma_ig.sv
// ERDMA ingress request generator: walks a 2-D surface in 32-byte atoms and issues
// DMA read requests of up to 8 atoms that never cross a 256-byte boundary, plus one context word per request.
module nv_nvdla_sdp_erdma_ig #(
  parameter int AW      = 64,
  parameter int CQ_PD_W = 16
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rst,
  input  logic              op_load,
  input  logic [AW-1:0]     reg2dp_base_addr,
  input  logic [12:0]       reg2dp_width,
  input  logic [12:0]       reg2dp_height,
  input  logic [AW-1:0]     reg2dp_line_stride,
  output logic              dma_rd_req_pvld,
  input  logic              dma_rd_req_prdy,
  output logic [AW+14:0]    dma_rd_req_pd,
  output logic              ig2cq_pvld,
  input  logic              ig2cq_prdy,
  output logic [CQ_PD_W-1:0] ig2cq_pd,
  output logic              op_busy,
  output logic              op_done
);

  // Handshake: a request transfers only when both dma_rd_req_prdy and ig2cq_prdy are high,
  // so each valid depends on the opposite side's ready and both interfaces fire together.
  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(31);

  state_t          state, state_nxt;
  logic [AW-1:0]   row_addr, cur_addr, stride_r, next_row;
  logic [12:0]     width_r;
  logic [13:0]     atoms_left;
  logic [12:0]     rows_left;
  logic            done_r;
  logic [3:0]      space, atoms, atoms_m1;
  logic            in_req, eor, eos, fire;

  assign in_req   = (state == REQ);
  assign space    = 4'd8 - {1'b0, cur_addr[7:5]};
  assign atoms    = (atoms_left < {10'd0, space}) ? atoms_left[3:0] : space;
  assign atoms_m1 = atoms - 4'd1;
  assign eor      = (atoms_left == {10'd0, atoms});
  assign eos      = eor && (rows_left == 13'd0);
  assign fire     = in_req && dma_rd_req_prdy && ig2cq_prdy;
  assign next_row = row_addr + stride_r;

  assign dma_rd_req_pvld = in_req && ig2cq_prdy;
  assign ig2cq_pvld      = in_req && dma_rd_req_prdy;
  assign dma_rd_req_pd   = in_req ? {11'd0, atoms_m1, cur_addr} : '0;
  assign op_busy         = in_req;
  assign op_done         = done_r;

  always_comb begin
    ig2cq_pd = '0;
    if (in_req) begin
      ig2cq_pd[2:0] = atoms_m1[2:0];
      ig2cq_pd[3]   = eor;
      ig2cq_pd[4]   = eos;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (op_load) state_nxt = REQ;
      REQ:     if (fire && eos) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) state <= IDLE;
    else                state <= state_nxt;
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      row_addr   <= '0;
      cur_addr   <= '0;
      stride_r   <= '0;
      width_r    <= '0;
      atoms_left <= '0;
      rows_left  <= '0;
      done_r     <= 1'b0;
    end else begin
      done_r <= fire && eos;
      if (state == IDLE && op_load) begin
        row_addr   <= reg2dp_base_addr & ALIGN_MASK;
        cur_addr   <= reg2dp_base_addr & ALIGN_MASK;
        stride_r   <= reg2dp_line_stride & ALIGN_MASK;
        width_r    <= reg2dp_width;
        atoms_left <= {1'b0, reg2dp_width} + 14'd1;
        rows_left  <= reg2dp_height;
      end else if (fire) begin
        if (eor) begin
          // The final row leaves the counters alone; the next load reinitialises them.
          if (!eos) begin
            row_addr   <= next_row;
            cur_addr   <= next_row;
            atoms_left <= {1'b0, width_r} + 14'd1;
            rows_left  <= rows_left - 13'd1;
          end
        end else begin
          cur_addr   <= cur_addr + ({{(AW-4){1'b0}}, atoms} << 5);
          atoms_left <= atoms_left - {10'd0, atoms};
        end
      end
    end
  end

endmodule
